// File: rtl/muldiv_ctrl.sv
// Iterative radix-2 multiply / restoring divide sequencer owning HI/LO.
// Optional MULDIV_EARLY_OUT_EN: MUL ends once remaining multiplier bits are zero.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             hilo_rd_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               mul_q, mul_d;
    logic               done_q, done_d;

    logic               sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     t, diff;
    logic [2*WIDTH-1:0] prod_n;
    logic               last, mul_last;

    assign sgn    = ~op_i[0];
    assign a_neg  = sgn & src_a_i[WIDTH-1];
    assign b_neg  = sgn & src_b_i[WIDTH-1];
    assign a_abs  = a_neg ? -src_a_i : src_a_i;
    assign b_abs  = b_neg ? -src_b_i : src_b_i;
    // Partial remainder shifted left with next dividend bit; needs WIDTH+1 bits.
    assign t      = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff   = t - {1'b0, y_q};
    assign prod_n = -acc_q;
    assign last   = (cnt_q == CW'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_last = last | (y_q[WIDTH-1:1] == '0);
`else
    assign mul_last = last;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        mul_d   = mul_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!flush_i) begin
                    if (hi_we_i) hi_d = wdata_i;
                    if (lo_we_i) lo_d = wdata_i;
                    if (start_i) begin
                        cnt_d  = '0;
                        y_d    = b_abs;
                        neg_d  = a_neg ^ b_neg;
                        rneg_d = a_neg;
                        mul_d  = ~op_i[1];
                        if (!op_i[1]) begin
                            acc_d   = '0;
                            x_d     = {{WIDTH{1'b0}}, a_abs};
                            state_d = MUL;
                        end else if (src_b_i == '0) begin
                            acc_d   = {src_a_i, {WIDTH{1'b1}}};
                            neg_d   = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = FIX;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, a_abs};
                            state_d = DIV;
                        end
                    end
                end
            end
            MUL: begin
                if (y_q[0]) acc_d = acc_q + x_q;
                x_d   = x_q << 1;
                y_d   = y_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (mul_last) state_d = FIX;
            end
            DIV: begin
                if (!diff[WIDTH])
                    acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {t[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (last) state_d = FIX;
            end
            FIX: begin
                if (mul_q) begin
                    {hi_d, lo_d} = neg_q ? prod_n : acc_q;
                end else begin
                    lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                                  : acc_q[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            mul_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            mul_q   <= mul_d;
            done_q  <= done_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign stall_o = busy_o & ~flush_i &
                     (start_i | hilo_rd_i | hi_we_i | lo_we_i);
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed ops, stalls, MTLO, flush, reset.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, flush_i, hi_we_i, lo_we_i, hilo_rd_i;
    logic [1:0]  op_i;
    logic [31:0] src_a_i, src_b_i, wdata_i;
    logic        stall_o, busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i),
        .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
        .hilo_rd_i(hilo_rd_i), .stall_o(stall_o), .busy_o(busy_o),
        .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int mul_lat(input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        int n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n + 2;
`else
        return 34;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("hi", hi_o, e.hi);
                chk("lo", lo_o, e.lo);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh,
                         input logic [31:0] el, input int lat,
                         input bit push);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        op_i    = op;
        src_a_i = a;
        src_b_i = b;
        if (push) q.push_back('{eh, el, cyc + lat});
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_o) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: busy still %b expected 0", nm, busy_o);
    endtask

    initial begin
        rst_n = 1'b0;
        start_i = 0; flush_i = 0; hi_we_i = 0; lo_we_i = 0;
        hilo_rd_i = 0; op_i = 0; src_a_i = 0; src_b_i = 0; wdata_i = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_done", {31'b0, done_o}, 0);
        chk("rst_stall", {31'b0, stall_o}, 0);

        // MULTU max*max with MFHI waiting behind it
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
              32'h00000001, 34, 1);
        hilo_rd_i = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (!busy_o) break;
                if (!stall_o) bad++;
            end
            chk("mfhi_stall_cycles_low", bad, 0);
        end
        chk("mfhi_stall_release", {31'b0, stall_o}, 0);
        chk("mfhi_busy_release", {31'b0, busy_o}, 0);
        hilo_rd_i = 1'b0;

        issue(2'b00, -32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1,
              mul_lat(5), 1);
        wait_idle("mult");
        issue(2'b10, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1);
        wait_idle("div_neg");
        issue(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 34, 1);
        wait_idle("divu");
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000,
              34, 1);
        wait_idle("div_ovf");
        issue(2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 2, 1);
        wait_idle("div0");

        // Independent instruction while busy, then MTLO behind it
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34, 1);
        @(negedge clk);
        chk("indep_busy", {31'b0, busy_o}, 1);
        chk("indep_stall", {31'b0, stall_o}, 0);
        #1;
        lo_we_i = 1'b1;
        wdata_i = 32'h1234;
        begin
            int bad = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (!busy_o) break;
                if (!stall_o) bad++;
            end
            chk("mtlo_stall_cycles_low", bad, 0);
        end
        chk("mtlo_stall_release", {31'b0, stall_o}, 0);
        @(posedge clk);
        #1 lo_we_i = 1'b0;
        @(negedge clk);
        chk("mtlo_lo", lo_o, 32'h1234);
        chk("mtlo_hi", hi_o, 32'd2);

        // Flushed start must not launch
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        start_i = 1'b1;
        op_i    = 2'b01;
        src_a_i = 32'd2;
        src_b_i = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'b0, busy_o}, 0);
        chk("flush_lo", lo_o, 32'h1234);
        chk("flush_hi", hi_o, 32'd2);

        // Reset in the middle of an iteration
        issue(2'b01, 32'hFFFF, 32'hFFFF, 0, 0, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        hilo_rd_i = 1'b1;
        #1;
        chk("pre_rst_stall", {31'b0, stall_o}, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy_o}, 0);
        chk("midrst_stall", {31'b0, stall_o}, 0);
        chk("midrst_hi", hi_o, 0);
        chk("midrst_lo", lo_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hilo_rd_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", {31'b0, busy_o}, 0);

        issue(2'b01, 32'd5, 32'd7, 32'd0, 32'd35, mul_lat(7), 1);
        wait_idle("early_out");

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer beside the execute stage ALU.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage using forwarded operands, then runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- Owns the HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall toward the hazard logic only when a dependent instruction reaches execute while the unit is busy.

Parameters:
- WIDTH, 32: operand, HI and LO width. The iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  pipeline clock; rising edge
- rst_n  input  1  reset; asynchronous, active-low
- start_i  input  1  execute stage holds a valid mult/div this cycle
- op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a_i  input  WIDTH  forwarded rs operand; multiplicand or dividend
- src_b_i  input  WIDTH  forwarded rt operand; multiplier or divisor
- flush_i  input  1  execute instruction squashed; suppresses start_i, hi_we_i, lo_we_i
- hi_we_i  input  1  MTHI
- lo_we_i  input  1  MTLO
- wdata_i  input  WIDTH  MTHI/MTLO data
- hilo_rd_i  input  1  execute stage holds MFHI or MFLO
- stall_o  output  1  freeze IF/ID/EX and bubble MEM
- busy_o  output  1  operation in flight
- done_o  output  1  one-cycle pulse when HI/LO receive a result
- hi_o  output  WIDTH  HI register; product upper half or remainder
- lo_o  output  WIDTH  LO register; product lower half or quotient

Behaviour:
- Reset (async, rst_n=0): state IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0, stall_o=0, counter=0, datapath registers cleared. Reset mid-operation discards the operation.
- FSM states are IDLE, MUL, DIV, FIX.
- busy_o=1 in MUL, DIV and FIX.
- Accept: in IDLE, start_i=1 and flush_i=0.
  - Latch magnitudes of the operands. Signed ops take two's-complement absolute values. Record the result sign and the remainder sign (dividend sign).
  - Clear the counter.
  - Go to MUL (op_i[1]=0) or DIV (op_i[1]=1).
- Divide by zero (src_b_i=0 on accept): skip iteration and go straight to FIX with lo=all-ones and hi=src_a_i. No sign fixup.
- MUL: one shift-add step per cycle; counter increments. After WIDTH steps go to FIX.
- DIV: one restoring subtract/shift step per cycle. After WIDTH steps go to FIX.
- FIX (1 cycle):
  - Apply sign fixup. MULT negates the 2*WIDTH product if the signs differ. DIV negates the quotient if the signs differ and negates the remainder if the dividend was negative.
  - Write HI/LO, pulse done_o=1, return to IDLE.
- Latency: accept at cycle 0; HI/LO valid in cycle WIDTH+2 (cycle 34 for WIDTH=32); divide-by-zero valid in cycle 2.
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- Stall rules:
  - stall_o = busy_o & ~flush_i & (start_i | hilo_rd_i | hi_we_i | lo_we_i). Combinational.
  - Drops in the cycle after FIX, so MFHI/MFLO sees the new value in IDLE.
  - Independent instructions proceed without stall while busy.
  - start_i in IDLE does not stall.
- MTHI/MTLO in IDLE write hi_o/lo_o on the next edge. hi_we_i and lo_we_i together write both.
- start_i together with hi_we_i/lo_we_i in IDLE: the write applies; the operation result later overwrites HI/LO.
- flush_i while busy does not abort the operation; it only masks new requests.
- hi_o/lo_o hold their values during MUL/DIV.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: MUL terminates and enters FIX once the remaining multiplier bits are all zero.
  - Minimum 1 iteration.
  - Example: 5*7 takes 3 MUL cycles.
  - done_o and stall release move earlier accordingly.
  - DIV is unchanged.
- Undefined: MUL always takes exactly WIDTH iterations.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, then MFHI issued next cycle -> stall_o=1 until done; hi_o=0xFFFFFFFE, lo_o=0x00000001; done_o single pulse at cycle 34 (no early-out).
- MULT -3*5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 7/2 -> lo_o=3, hi_o=1.
- DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0. DIVU 9/0 -> lo_o=0xFFFFFFFF, hi_o=9, done_o at cycle 2.
- Busy with an add in EX -> stall_o=0. MTLO 0x1234 while busy -> stall_o=1 until idle; lo_o=0x1234 the cycle after the write.
- start_i with flush_i=1 -> busy_o stays 0, HI/LO unchanged. rst_n low at iteration 10 -> immediate IDLE, hi_o=lo_o=0, stall_o=0.
- MULDIV_EARLY_OUT_EN defined, MULTU 5*7 -> lo_o=35, done_o at cycle 5. Undefined -> done_o at cycle 34.
